// File: rtl/qdec_pkg.sv
// Shared types and constants for the NAL unit / emulation-prevention stripper.
// Contents: FSM state enum, special byte values, NAL header struct and a
// helper that decodes the two captured header bytes.
package qdec_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned ZC_W          = 2;
  localparam int unsigned NAL_HDR_BYTES = 2;
  // Header bits kept after the forbidden_zero_bit has been checked and dropped.
  localparam int unsigned HDR_RAW_W     = NAL_HDR_BYTES * BYTE_W - 1;

  localparam logic [BYTE_W-1:0] ZERO_BYTE      = 8'h00;
  localparam logic [BYTE_W-1:0] START_CODE_LSB = 8'h01;
  localparam logic [BYTE_W-1:0] ILLEGAL_BYTE   = 8'h02;
  localparam logic [BYTE_W-1:0] EPB_BYTE       = 8'h03;

  localparam logic [ZC_W-1:0] ZC_ONE = ZC_W'(1);
  localparam logic [ZC_W-1:0] ZC_TWO = ZC_W'(2);
  localparam logic [ZC_W-1:0] ZC_MAX = ZC_W'(3);

  typedef enum logic [2:0] {
    S_SEARCH,
    S_HDR0,
    S_HDR1,
    S_PAY,
    S_FLUSH
  } nal_state_e;

  typedef struct packed {
    logic [5:0] unit_type;
    logic [5:0] layer_id;
    logic [2:0] tid;
  } nal_hdr_t;

  // raw = {byte0[6:0], byte1}; the temporal id is coded as tid+1.
  function automatic nal_hdr_t decode_hdr(input logic [HDR_RAW_W-1:0] raw);
    nal_hdr_t h;
    h.unit_type = raw[14:9];
    h.layer_id  = raw[8:3];
    h.tid       = raw[2:0] - 3'(1);
    return h;
  endfunction

endpackage

// File: rtl/qdec_byte_skid.sv
// Single-entry output register with valid/ready handshake.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data load a new byte (only when can_push_c is high)
//   out_data/vld    registered byte towards the consumer
//   out_rdy         consumer ready
//   can_push_c      register is empty or draining this cycle
module qdec_byte_skid
  import qdec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              out_rdy,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_vld,
  output logic              can_push_c
);

  assign can_push_c = ~out_vld | out_rdy;

  // Data only changes on a load, so it stays stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (push) begin
      out_vld  <= 1'b1;
      out_data <= push_data;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/qdec_nal_epb_strip.sv
// Annex-B start-code finder, NAL header capture and emulation-prevention
// byte stripper feeding the CABAC decoder with clean RBSP bytes.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   raw_byte/_vld/_rdy            Annex-B byte stream in
//   bitstreamFetch/_vld/_rdy      RBSP byte stream out (1-cycle latency)
//   nal_unit_type, nuh_layer_id,
//   nuh_temporal_id               header fields, held until next nal_hdr_vld
//   nal_hdr_vld, nal_end,
//   epb_removed, syntax_err       single-cycle event pulses
// Optional (QDEC_NAL_EPB_STATS_EN):
//   stat_epb_cnt, stat_byte_cnt   per-NAL saturating counters
module qdec_nal_epb_strip
  import qdec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] raw_byte,
  input  logic              raw_byte_vld,
  output logic              raw_byte_rdy,
  output logic [BYTE_W-1:0] bitstreamFetch,
  output logic              bitstreamFetch_vld,
  input  logic              bitstreamFetch_rdy,
  output logic [5:0]        nal_unit_type,
  output logic [5:0]        nuh_layer_id,
  output logic [2:0]        nuh_temporal_id,
  output logic              nal_hdr_vld,
  output logic              nal_end,
  output logic              epb_removed,
  output logic              syntax_err
`ifdef QDEC_NAL_EPB_STATS_EN
  ,
  output logic [15:0]       stat_epb_cnt,
  output logic [23:0]       stat_byte_cnt
`endif
);

  nal_state_e        state;
  logic [ZC_W-1:0]   zc;
  logic [BYTE_W-1:0] hold_byte;
  logic              hold_vld;
  logic [6:0]        hdr_b0;
  nal_hdr_t          hdr;

  logic              can_push_c;
  logic              acc_c;
  logic              push_c;
  logic [BYTE_W-1:0] push_data_c;
  logic              hdr_cap_c;

  assign raw_byte_rdy = ~rst & (state != S_FLUSH) & can_push_c;
  assign acc_c        = raw_byte_vld & raw_byte_rdy;
  assign hdr_cap_c    = (state == S_HDR1) & acc_c;

  assign nal_unit_type   = hdr.unit_type;
  assign nuh_layer_id    = hdr.layer_id;
  assign nuh_temporal_id = hdr.tid;

  // Output load: direct pass-through in payload, or zero/held-byte replay.
  always_comb begin
    push_c      = 1'b0;
    push_data_c = ZERO_BYTE;
    case (state)
      S_PAY: begin
        if (acc_c && (zc == '0) && (raw_byte != ZERO_BYTE)) begin
          push_c      = 1'b1;
          push_data_c = raw_byte;
        end
      end
      S_FLUSH: begin
        if (can_push_c) begin
          push_c      = 1'b1;
          push_data_c = (zc != '0) ? ZERO_BYTE : hold_byte;
        end
      end
      default: ;
    endcase
  end

  qdec_byte_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (push_c),
    .push_data  (push_data_c),
    .out_rdy    (bitstreamFetch_rdy),
    .out_data   (bitstreamFetch),
    .out_vld    (bitstreamFetch_vld),
    .can_push_c (can_push_c)
  );

  // Main byte classifier; zc counts zeros that have not been forwarded yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_SEARCH;
      zc          <= '0;
      hold_byte   <= '0;
      hold_vld    <= 1'b0;
      hdr_b0      <= '0;
      hdr         <= '0;
      nal_hdr_vld <= 1'b0;
      nal_end     <= 1'b0;
      epb_removed <= 1'b0;
      syntax_err  <= 1'b0;
    end else begin
      nal_hdr_vld <= 1'b0;
      nal_end     <= 1'b0;
      epb_removed <= 1'b0;
      syntax_err  <= 1'b0;

      case (state)
        S_SEARCH: begin
          if (acc_c) begin
            if (raw_byte == ZERO_BYTE) begin
              zc <= (zc == ZC_MAX) ? ZC_MAX : zc + ZC_ONE;
            end else if ((raw_byte == START_CODE_LSB) && (zc >= ZC_TWO)) begin
              state <= S_HDR0;
              zc    <= '0;
            end else begin
              zc <= '0;
            end
          end
        end

        S_HDR0: begin
          if (acc_c) begin
            if (raw_byte[7]) begin
              syntax_err <= 1'b1;
              state      <= S_SEARCH;
              zc         <= '0;
            end else begin
              hdr_b0 <= raw_byte[6:0];
              state  <= S_HDR1;
            end
          end
        end

        S_HDR1: begin
          if (acc_c) begin
            hdr         <= decode_hdr({hdr_b0, raw_byte});
            nal_hdr_vld <= 1'b1;
            state       <= S_PAY;
            zc          <= '0;
          end
        end

        S_PAY: begin
          if (acc_c) begin
            if (zc == ZC_TWO) begin
              case (raw_byte)
                ZERO_BYTE: begin
                  nal_end <= 1'b1;
                  state   <= S_SEARCH;
                  zc      <= ZC_MAX;
                end
                // The two zeros are real data: replay them without a tail byte.
                EPB_BYTE: begin
                  epb_removed <= 1'b1;
                  hold_vld    <= 1'b0;
                  state       <= S_FLUSH;
                end
                START_CODE_LSB: begin
                  nal_end <= 1'b1;
                  state   <= S_HDR0;
                  zc      <= '0;
                end
                ILLEGAL_BYTE: begin
                  syntax_err <= 1'b1;
                  state      <= S_SEARCH;
                  zc         <= '0;
                end
                default: begin
                  hold_byte <= raw_byte;
                  hold_vld  <= 1'b1;
                  state     <= S_FLUSH;
                end
              endcase
            end else if (raw_byte == ZERO_BYTE) begin
              zc <= zc + ZC_ONE;
            end else if (zc != '0) begin
              hold_byte <= raw_byte;
              hold_vld  <= 1'b1;
              state     <= S_FLUSH;
            end
          end
        end

        S_FLUSH: begin
          if (can_push_c) begin
            if (zc != '0) begin
              zc <= zc - ZC_ONE;
              if ((zc == ZC_ONE) && !hold_vld) begin
                state <= S_PAY;
              end
            end else begin
              state <= S_PAY;
            end
          end
        end

        default: begin
          state <= S_SEARCH;
          zc    <= '0;
        end
      endcase
    end
  end

`ifdef QDEC_NAL_EPB_STATS_EN
  // Per-NAL saturating statistics, restarted with each new header.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_epb_cnt  <= '0;
      stat_byte_cnt <= '0;
    end else if (hdr_cap_c) begin
      stat_epb_cnt  <= '0;
      stat_byte_cnt <= '0;
    end else begin
      if (epb_removed && (stat_epb_cnt != '1)) begin
        stat_epb_cnt <= stat_epb_cnt + 16'(1);
      end
      if (push_c && (stat_byte_cnt != '1)) begin
        stat_byte_cnt <= stat_byte_cnt + 24'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_qdec_nal_epb_strip.sv
// Self-checking bench for qdec_nal_epb_strip: table of byte-stream vectors
// with an output scoreboard, plus hand-written flush/reset sequences.
module tb_qdec_nal_epb_strip;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] raw_byte;
  logic       raw_byte_vld;
  logic       raw_byte_rdy;
  logic [7:0] bitstreamFetch;
  logic       bitstreamFetch_vld;
  logic       bitstreamFetch_rdy;
  logic [5:0] nal_unit_type;
  logic [5:0] nuh_layer_id;
  logic [2:0] nuh_temporal_id;
  logic       nal_hdr_vld;
  logic       nal_end;
  logic       epb_removed;
  logic       syntax_err;
`ifdef QDEC_NAL_EPB_STATS_EN
  logic [15:0] stat_epb_cnt;
  logic [23:0] stat_byte_cnt;
`endif

  always #5 clk = ~clk;

  qdec_nal_epb_strip dut (
    .clk                (clk),
    .rst                (rst),
    .raw_byte           (raw_byte),
    .raw_byte_vld       (raw_byte_vld),
    .raw_byte_rdy       (raw_byte_rdy),
    .bitstreamFetch     (bitstreamFetch),
    .bitstreamFetch_vld (bitstreamFetch_vld),
    .bitstreamFetch_rdy (bitstreamFetch_rdy),
    .nal_unit_type      (nal_unit_type),
    .nuh_layer_id       (nuh_layer_id),
    .nuh_temporal_id    (nuh_temporal_id),
    .nal_hdr_vld        (nal_hdr_vld),
    .nal_end            (nal_end),
    .epb_removed        (epb_removed),
    .syntax_err         (syntax_err)
`ifdef QDEC_NAL_EPB_STATS_EN
    ,
    .stat_epb_cnt       (stat_epb_cnt),
    .stat_byte_cnt      (stat_byte_cnt)
`endif
  );

  typedef struct {
    int           n_raw;
    logic [127:0] raw;
    int           n_exp;
    logic [63:0]  exp;
    int           mode;
    int           hdr;
    int           nend;
    int           epb;
    int           err;
    int           typ;
    int           layer;
    int           tid;
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] exp_q [$];
  int         total = 0;
  int         bad   = 0;
  int         n_hdr, n_end, n_epb, n_err, n_out;
  int         last_type, last_layer, last_tid;
  int         rdy_mode = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, want, want);
    end
  endtask

  function automatic vec_t mk(input int nr, input logic [127:0] r, input int ne,
                              input logic [63:0] e, input int mode, input int h,
                              input int nd, input int ep, input int er,
                              input int ty, input int la, input int ti);
    vec_t v;
    v.n_raw = nr; v.raw = r; v.n_exp = ne; v.exp = e; v.mode = mode;
    v.hdr = h; v.nend = nd; v.epb = ep; v.err = er;
    v.typ = ty; v.layer = la; v.tid = ti;
    return v;
  endfunction

  // Consumer-side ready pattern: 0 always, 1 toggle, 2 random, 3 stalled.
  initial begin
    bitstreamFetch_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bitstreamFetch_rdy = 1'b1;
        1:       bitstreamFetch_rdy = ~bitstreamFetch_rdy;
        2:       bitstreamFetch_rdy = 1'($urandom_range(0, 1));
        default: bitstreamFetch_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: pulse counters, scoreboard pop and stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (nal_hdr_vld) begin
        n_hdr++;
        last_type  = int'(nal_unit_type);
        last_layer = int'(nuh_layer_id);
        last_tid   = int'(nuh_temporal_id);
      end
      if (nal_end)     n_end++;
      if (epb_removed) n_epb++;
      if (syntax_err)  n_err++;
      if (prev_stall) begin
        check("stall_vld", int'(bitstreamFetch_vld), 1);
        check("stall_data", int'(bitstreamFetch), int'(prev_data));
      end
      if (bitstreamFetch_vld && bitstreamFetch_rdy) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("extra_out_byte", int'(bitstreamFetch), -1);
        end else begin
          check("out_byte", int'(bitstreamFetch), int'(exp_q.pop_front()));
        end
      end
      prev_stall = bitstreamFetch_vld && !bitstreamFetch_rdy;
      prev_data  = bitstreamFetch;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    raw_byte_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_hdr = 0; n_end = 0; n_epb = 0; n_err = 0; n_out = 0;
    last_type = -1; last_layer = -1; last_tid = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    raw_byte = b;
    raw_byte_vld = 1'b1;
    @(negedge clk);
    while (!raw_byte_rdy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!raw_byte_rdy) check("raw_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    raw_byte_vld = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic send_bytes(input int n, input logic [127:0] r);
    logic [127:0] t;
    for (int i = 0; i < n; i++) begin
      t = r >> (8 * (n - 1 - i));
      send_byte(t[7:0]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t;
    int          out0;
    rst = 1'b1;
    raw_byte = 8'h00;
    raw_byte_vld = 1'b0;

    vecs[0] = mk(7,  128'h000001_4001_AABB,                  2, 64'hAABB,       0, 1, 0, 0, 0, 32, 0,  0);
    vecs[1] = mk(11, 128'h000001_4001_12000003_0134,         5, 64'h1200000134, 1, 1, 0, 1, 0, 32, 0,  0);
    vecs[2] = mk(11, 128'h000001_4001_55000001_2601,         1, 64'h55,         0, 2, 1, 0, 0, 19, 0,  0);
    vecs[3] = mk(7,  128'h000001_4001_007F,                  2, 64'h007F,       1, 1, 0, 0, 0, 32, 0,  0);
    vecs[4] = mk(14, 128'h000001_4001_000002_000001_4001_C3, 1, 64'hC3,        0, 2, 0, 0, 1, 32, 0,  0);
    vecs[5] = mk(11, 128'h000001_C0_01_000001_0201_77,      1, 64'h77,         2, 1, 0, 0, 1, 1,  0,  0);
    vecs[6] = mk(14, 128'h000001_4001_000003_000000_01_4401, 2, 64'h0000,      0, 2, 1, 1, 0, 34, 0,  0);
    vecs[7] = mk(8,  128'h000001_41F3_AB00AB,                3, 64'hAB00AB,     2, 1, 0, 0, 0, 32, 62, 2);
    vecs[8] = mk(10, 128'h000001_4001_000005_0003,           5, 64'h0000050003, 2, 1, 0, 0, 0, 32, 0,  0);
    vecs[9] = mk(8,  128'h11_000000_01_4001_66,              1, 64'h66,         0, 1, 0, 0, 0, 32, 0,  0);

    // Reset state, sampled while reset is still held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_vld", int'(bitstreamFetch_vld), 0);
    check("rst_out_data", int'(bitstreamFetch), 0);
    check("rst_raw_rdy", int'(raw_byte_rdy), 0);
    check("rst_pulses", int'({nal_hdr_vld, nal_end, epb_removed, syntax_err}), 0);
    check("rst_fields", int'({nal_unit_type, nuh_layer_id, nuh_temporal_id}), 0);
    rst = 1'b0;
    #1;
    check("raw_rdy_after_rst", int'(raw_byte_rdy), 1);

    for (int k = 0; k < 10; k++) begin
      do_reset();
      rdy_mode = vecs[k].mode;
      for (int j = 0; j < vecs[k].n_exp; j++) begin
        t = vecs[k].exp >> (8 * (vecs[k].n_exp - 1 - j));
        exp_q.push_back(t[7:0]);
      end
      send_bytes(vecs[k].n_raw, vecs[k].raw);
      drain();
      check($sformatf("v%0d_hdr_cnt", k), n_hdr, vecs[k].hdr);
      check($sformatf("v%0d_end_cnt", k), n_end, vecs[k].nend);
      check($sformatf("v%0d_epb_cnt", k), n_epb, vecs[k].epb);
      check($sformatf("v%0d_err_cnt", k), n_err, vecs[k].err);
      check($sformatf("v%0d_out_cnt", k), n_out, vecs[k].n_exp);
      if (vecs[k].hdr > 0) begin
        check($sformatf("v%0d_type", k), last_type, vecs[k].typ);
        check($sformatf("v%0d_layer", k), last_layer, vecs[k].layer);
        check($sformatf("v%0d_tid", k), last_tid, vecs[k].tid);
      end
`ifdef QDEC_NAL_EPB_STATS_EN
      if (k == 1) begin
        check("stat_epb", int'(stat_epb_cnt), 1);
        check("stat_bytes", int'(stat_byte_cnt), 5);
      end
`endif
    end

    // Input is blocked for the cycle after a byte enters the flush path.
    do_reset();
    rdy_mode = 0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h7F);
    send_bytes(7, 128'h000001_4001_007F);
    @(negedge clk);
    check("raw_rdy_in_flush", int'(raw_byte_rdy), 0);
    drain();
    check("flush_out_cnt", n_out, 2);

    // Reset while stalled in flush with 9A held: 9A must never appear.
    do_reset();
    rdy_mode = 3;
    send_bytes(7, 128'h000001_4001_009A);
    repeat (3) @(negedge clk);
    check("stall_flush_vld", int'(bitstreamFetch_vld), 1);
    check("stall_flush_data", int'(bitstreamFetch), 0);
    check("stall_flush_raw_rdy", int'(raw_byte_rdy), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_vld", int'(bitstreamFetch_vld), 0);
    check("midrst_out_data", int'(bitstreamFetch), 0);
    check("midrst_raw_rdy", int'(raw_byte_rdy), 0);
    check("midrst_type", int'(nal_unit_type), 0);
    check("midrst_pulses", int'({nal_hdr_vld, nal_end, epb_removed, syntax_err}), 0);
    rst = 1'b0;
    rdy_mode = 0;
    out0 = n_out;
    repeat (12) @(negedge clk);
    check("midrst_no_output", n_out - out0, 0);
    check("midrst_vld_idle", int'(bitstreamFetch_vld), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
